// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator for the single-port data memory: alternates READ/WRITE cycles to copy LEN words SRC->DST.
// Optional running sum of written words when MEM_COPY_CHECKSUM_EN is defined (adds the checksum port).
module mem_copy_dma #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16,
    parameter int unsigned LW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] remaining;

    // Outputs are registered from the next state; mem_wd doubles as the read buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (len != LW'(0)) begin
                            state    <= READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= src_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state    <= WRITE;
                        busy     <= 1'b1;
                        mem_wr   <= 1'b1;
                        mem_addr <= dst_ptr;
                        mem_wd   <= mem_rdata;
                    end
                end
                WRITE: begin
                    // The write lands on this edge even if aborted, so it is always counted.
                    src_ptr   <= src_ptr + AW'(1);
                    dst_ptr   <= dst_ptr + AW'(1);
                    remaining <= remaining - LW'(1);
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum  <= checksum + mem_wd;
`endif
                    if (abort) begin
                        state <= IDLE;
                    end else if (remaining > LW'(1)) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= src_ptr + AW'(1);
                    end else begin
                        state <= DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: memory model, write scoreboard and per-cycle protocol checks.
module tb_mem_copy_dma;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  excl_viol = 0;

    mem_copy_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rdata (mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every memory write must match the oldest expected write.
    always @(posedge clk) begin
        if (mem_rd && mem_wr) excl_viol++;
        if (mem_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
                check("wr_data", 32'(mem_wd), 32'(mon_e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_copy(input int n, input logic [AW-1:0] s, input logic [AW-1:0] d);
        logic exp_rd, exp_wr;
        logic [AW-1:0] exp_a;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{a: d + AW'(i), d: mem[s + AW'(i)]});
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int c = 1; c <= 2*n + 1; c++) begin
            exp_rd = (c % 2 == 1) && (c <= 2*n);
            exp_wr = (c % 2 == 0) && (c <= 2*n);
            exp_a  = exp_rd ? s + AW'((c-1)/2) : (exp_wr ? d + AW'((c-2)/2) : '0);
            check("busy",     32'(busy),     32'(1'b1));
            check("done",     32'(done),     32'(c == 2*n + 1));
            check("mem_rd",   32'(mem_rd),   32'(exp_rd));
            check("mem_wr",   32'(mem_wr),   32'(exp_wr));
            check("mem_addr", 32'(mem_addr), 32'(exp_a));
            tick();
        end
        check("idle_busy", 32'(busy), 32'(1'b0));
        check("idle_done", 32'(done), 32'(1'b0));
        check("queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        #12;
        check("rst_busy",   32'(busy),     32'(0));
        check("rst_done",   32'(done),     32'(0));
        check("rst_rd",     32'(mem_rd),   32'(0));
        check("rst_wr",     32'(mem_wr),   32'(0));
        check("rst_addr",   32'(mem_addr), 32'(0));
        check("rst_wd",     32'(mem_wd),   32'(0));
        rst_n = 1'b1;
        tick();

        // Basic two-word copy
        mem[3] = 16'h1004;
        mem[4] = 16'h0008;
        run_copy(2, 12'd3, 12'd100);
        check("t1_mem100", 32'(mem[100]), 32'h1004);
        check("t1_mem101", 32'(mem[101]), 32'h0008);
`ifdef MEM_COPY_CHECKSUM_EN
        check("t1_checksum", 32'(checksum), 32'h100C);
`endif

        // Zero-length: done in cycle 1, no access
        run_copy(0, 12'd10, 12'd20);
        check("t2_mem20", 32'(mem[20]), 32'(16'd20 ^ 16'h5A5A));

        // Source pointer wrap
        mem[12'hFFF] = 16'hAAAA;
        mem[0]       = 16'h5555;
        run_copy(2, 12'hFFF, 12'h200);
        check("t3_mem200", 32'(mem[12'h200]), 32'hAAAA);
        check("t3_mem201", 32'(mem[12'h201]), 32'h5555);

        // Ignored restart, abort during a write
        for (int i = 0; i < 2; i++) exp_q.push_back('{a: 12'h400 + AW'(i), d: mem[12'h300 + AW'(i)]});
        src_addr = 12'h300; dst_addr = 12'h400; len = 12'd8; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        check("t4_c2_wr", 32'(mem_wr), 32'(1));
        tick();                                   // cycle 3
        src_addr = 12'h700; dst_addr = 12'h710; len = 12'd3; start = 1'b1;
        check("t4_c3_rd_addr", 32'(mem_addr), 32'h301);
        tick();                                   // cycle 4
        start = 1'b0; abort = 1'b1;
        check("t4_c4_wr", 32'(mem_wr), 32'(1));
        check("t4_c4_addr", 32'(mem_addr), 32'h401);
        tick();                                   // cycle 5
        abort = 1'b0;
        check("t4_c5_busy", 32'(busy), 32'(0));
        check("t4_c5_rd", 32'(mem_rd), 32'(0));
        for (int c = 0; c < 4; c++) begin
            check("t4_no_done", 32'(done), 32'(0));
            check("t4_no_busy", 32'(busy), 32'(0));
            tick();
        end
        check("t4_mem400", 32'(mem[12'h400]), 32'(16'h300 ^ 16'h5A5A));
        check("t4_mem401", 32'(mem[12'h401]), 32'(16'h301 ^ 16'h5A5A));
        check("t4_mem402", 32'(mem[12'h402]), 32'(16'h402 ^ 16'h5A5A));
        check("t4_queue", 32'(exp_q.size()), 32'(0));

        // Reset mid-transfer
        exp_q.push_back('{a: 12'h600, d: mem[12'h500]});
        src_addr = 12'h500; dst_addr = 12'h600; len = 12'd4; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy),     32'(0));
        check("t5_done", 32'(done),     32'(0));
        check("t5_rd",   32'(mem_rd),   32'(0));
        check("t5_wr",   32'(mem_wr),   32'(0));
        check("t5_addr", 32'(mem_addr), 32'(0));
        check("t5_wd",   32'(mem_wd),   32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_mem600", 32'(mem[12'h600]), 32'(16'h500 ^ 16'h5A5A));
        check("t5_mem601", 32'(mem[12'h601]), 32'(16'h601 ^ 16'h5A5A));
        run_copy(1, 12'h510, 12'h610);
        check("t5_mem610", 32'(mem[12'h610]), 32'(16'h510 ^ 16'h5A5A));

`ifdef MEM_COPY_CHECKSUM_EN
        // Checksum wraps modulo 2**DW
        mem[5] = 16'hFFFF;
        mem[6] = 16'hFFFF;
        run_copy(2, 12'd5, 12'h220);
        check("t6_checksum", 32'(checksum), 32'hFFFE);
`endif

        check("rd_wr_exclusive", 32'(excl_viol), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
